dmem_responder: RTL and testbench

//  Data-memory responder: the slave end of the CPU's data-memory port (mem_addr/mem_wdata/mem_write/mem_read -> mem_rdata).

---
 rtl/dmem_pkg.sv | 6 +
 rtl/dmem_ram.sv | 17 +
 rtl/dmem_responder.sv | 68 ++++++
 tb/tb_dmem_responder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and constants for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2, DRAIN = 2'd3} state_t;
  localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;
  localparam logic [15:0] ERR_RDATA = 16'h0000;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous DEPTH x 16 RAM with one-cycle read
module dmem_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  logic [15:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory slave with RAM, io_out register and error flagging
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH   = 256,
  parameter int          RD_LAT  = 2,
  parameter logic [15:0] IO_ADDR = IO_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic [15:0] io_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RD_LAT + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [15:0] addr_q, ram_rdata;
  logic rd_q, wr_q, acc, legal_wr, we, lat_io, err, done;
  assign acc = state == IDLE && (mem_read || mem_write);
  assign legal_wr = acc && mem_write && !mem_read && !rst;
  assign we = legal_wr && 32'(mem_addr) < DEPTH;
  assign lat_io = addr_q == IO_ADDR;
  assign err = (rd_q && wr_q) || !(32'(addr_q) < DEPTH || lat_io);
  assign done = state == WAIT && cnt == '0;
  assign mem_ready = state == RESP;
  dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(we),
    .addr(state == IDLE ? mem_addr[AW-1:0] : addr_q[AW-1:0]),
    .wdata(mem_wdata),
    .rdata(ram_rdata)
  );
  always_comb begin
    state_nx = state == IDLE ? (acc ? WAIT : IDLE) :
               state == WAIT ? (done ? RESP : WAIT) :
               state == RESP ? DRAIN :
               (mem_read || mem_write ? DRAIN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mem_rdata <= '0;
      mem_err <= 1'b0;
      io_out <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        addr_q <= mem_addr;
        rd_q <= mem_read;
        wr_q <= mem_write;
        cnt <= CW'(RD_LAT - 1);
      end else if (state == WAIT && cnt != '0) cnt <= cnt - CW'(1);
      if (legal_wr && mem_addr == IO_ADDR) io_out <= mem_wdata;
      if (done) begin
        mem_err <= err;
        mem_rdata <= err ? ERR_RDATA : rd_q ? (lat_io ? io_out : ram_rdata) : mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus against a transaction-level model of the responder
module tb_dmem_responder;
  localparam int RD_LAT = 2;
  logic clk = 1'b0, rst = 1'b1, mem_write = 1'b0, mem_read = 1'b0;
  logic [15:0] mem_addr = '0, mem_wdata = '0;
  logic [15:0] mem_rdata, io_out;
  logic mem_ready, mem_err;
  dmem_responder #(.DEPTH(256), .RD_LAT(RD_LAT), .IO_ADDR(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_err(mem_err), .io_out(io_out)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0, pulses = 0, exp_cyc = 0, obs_cyc = 0, acc = 0;
  bit started = 0, exp_valid = 0, exp_err = 0, m_err = 0, obs_err = 0;
  logic [15:0] mram [256];
  logic [15:0] mio = '0, exp_rdata = '0, m_rdata = '0, obs_rdata = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    bit hit;
    if (started) begin
      hit = exp_valid && cyc == exp_cyc;
      if (hit) begin
        m_rdata = exp_rdata;
        m_err = exp_err;
        exp_valid = 0;
      end
      if (mem_ready === 1'b1) begin
        pulses++;
        obs_rdata = mem_rdata;
        obs_err = mem_err;
        obs_cyc = cyc;
      end
      chk("ready", 16'(mem_ready), 16'(hit));
      chk("rdata", mem_rdata, m_rdata);
      chk("err", 16'(mem_err), 16'(m_err));
      chk("io_out", io_out, mio);
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    exp_valid = 0;
    mio = '0;
    m_rdata = '0;
    m_err = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic req(input logic [15:0] a, input logic [15:0] wd, input bit rd, input bit wr,
                     input int hold, input bit wait_resp, output int acc_cyc);
    bit bad, in_ram, in_io;
    @(negedge clk);
    mem_addr = a;
    mem_wdata = wd;
    mem_read = rd;
    mem_write = wr;
    acc_cyc = cyc + 1;
    @(posedge clk);
    in_ram = a < 16'd256;
    in_io = a == 16'hFFFF;
    bad = (rd && wr) || !(in_ram || in_io);
    exp_err = bad;
    exp_rdata = bad ? 16'h0000 : rd ? (in_ram ? mram[a[7:0]] : mio) : m_rdata;
    if (!bad && wr) begin
      if (in_ram) mram[a[7:0]] = wd;
      else mio = wd;
    end
    exp_cyc = acc_cyc + RD_LAT;
    exp_valid = 1;
    repeat (hold) @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
    if (wait_resp) begin
      repeat (RD_LAT + 2) @(negedge clk);
      if (exp_valid) begin
        n_chk++;
        n_fail++;
        $display("FAIL resp_timeout: no response by cycle %0d, required at cycle %0d", cyc, exp_cyc);
        exp_valid = 0;
      end
    end
  endtask
  initial begin
    int p0;
    for (int i = 0; i < 256; i++) mram[i] = '0;
    @(negedge clk);
    do_reset();
    started = 1;
    chk("reset_rdata", mem_rdata, 16'h0000);
    chk("reset_io", io_out, 16'h0000);
    req(16'd5, 16'h1234, 0, 1, 1, 1, acc);
    req(16'd5, 16'h0000, 1, 0, 1, 1, acc);
    chk("t1_rdata", obs_rdata, 16'h1234);
    chk("t1_err", 16'(obs_err), 16'h0000);
    chk("t1_latency", 16'(obs_cyc - acc), 16'd2);
    req(16'hFFFF, 16'hA5A5, 0, 1, 1, 1, acc);
    chk("t2_io", io_out, 16'hA5A5);
    chk("t2_wr_keeps_rdata", obs_rdata, 16'h1234);
    req(16'hFFFF, 16'h0000, 1, 0, 1, 1, acc);
    chk("t2_rdata", obs_rdata, 16'hA5A5);
    req(16'd0, 16'h0777, 0, 1, 1, 1, acc);
    req(16'h0100, 16'h0000, 1, 0, 1, 1, acc);
    chk("t3_rd_err", 16'(obs_err), 16'h0001);
    chk("t3_rd_rdata", obs_rdata, 16'h0000);
    req(16'h0100, 16'hDEAD, 0, 1, 1, 1, acc);
    chk("t3_wr_err", 16'(obs_err), 16'h0001);
    req(16'd0, 16'h0000, 1, 0, 1, 1, acc);
    chk("t3_ram0", obs_rdata, 16'h0777);
    req(16'hFFFE, 16'h0000, 1, 0, 1, 1, acc);
    chk("t3_nearby_err", 16'(obs_err), 16'h0001);
    req(16'd7, 16'h0042, 0, 1, 1, 1, acc);
    req(16'd7, 16'hFFFF, 1, 1, 1, 1, acc);
    chk("t4_err", 16'(obs_err), 16'h0001);
    chk("t4_rdata", obs_rdata, 16'h0000);
    req(16'd7, 16'h0000, 1, 0, 1, 1, acc);
    chk("t4_ram7", obs_rdata, 16'h0042);
    p0 = pulses;
    req(16'd5, 16'h0000, 1, 0, 10, 1, acc);
    chk("t5_one_pulse", 16'(pulses - p0), 16'd1);
    chk("t5_rdata", obs_rdata, 16'h1234);
    req(16'd5, 16'h0000, 1, 0, 1, 1, acc);
    chk("t5_second_pulse", 16'(pulses - p0), 16'd2);
    p0 = pulses;
    req(16'd3, 16'hBEEF, 0, 1, 1, 0, acc);
    do_reset();
    repeat (4) @(negedge clk);
    chk("t6_no_pulse", 16'(pulses - p0), 16'd0);
    chk("t6_io", io_out, 16'h0000);
    chk("t6_rdata", mem_rdata, 16'h0000);
    req(16'd3, 16'h0000, 1, 0, 1, 1, acc);
    chk("t6_ram3", obs_rdata, 16'hBEEF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
